// File: rtl/execution_barrel_shifter.sv
// Pipelined barrel shifter for the EX stage: SLL/SRL/SRA/ROTR over STAGES register stages,
// with a passthrough destination tag, valid/ready back-pressure and a synchronous flush.
module execution_barrel_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STAGES  = 2,
    parameter int TAG_W   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag
);

    // Cascade level j is applied in stage j / LEVELS_PER_STAGE.
    localparam int LEVELS_PER_STAGE = (SHAMT_W + STAGES - 1) / STAGES;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_ROTR = 2'b11
    } op_e;

    logic [STAGES-1:0]  r_valid;
    logic [WIDTH-1:0]   r_data  [STAGES];
    op_e                r_op    [STAGES];
    logic [TAG_W-1:0]   r_tag   [STAGES];
    logic [SHAMT_W-1:0] r_shamt [STAGES];

    logic [STAGES-1:0]  w_valid_in;
    logic [STAGES-1:0]  w_adv;
    logic [WIDTH-1:0]   w_data_in  [STAGES];
    logic [WIDTH-1:0]   w_shifted  [STAGES];
    op_e                w_op_in    [STAGES];
    logic [TAG_W-1:0]   w_tag_in   [STAGES];
    logic [SHAMT_W-1:0] w_shamt_in [STAGES];

    // SRA keeps the MSB, so the sign sampled at input survives every partial shift.
    function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                     input op_e op, input int amt);
        case (op)
            OP_SLL:  return d << amt;
            OP_SRL:  return d >> amt;
            OP_SRA:  return $signed(d) >>> amt;
            default: return (d >> amt) | (d << (WIDTH - amt));
        endcase
    endfunction

    always_comb begin
        w_valid_in[0] = in_valid;
        w_data_in[0]  = in_data;
        w_op_in[0]    = op_e'(in_op);
        w_tag_in[0]   = in_tag;
        w_shamt_in[0] = in_shamt;
        for (int k = 1; k < STAGES; k++) begin
            w_valid_in[k] = r_valid[k-1];
            w_data_in[k]  = r_data[k-1];
            w_op_in[k]    = r_op[k-1];
            w_tag_in[k]   = r_tag[k-1];
            w_shamt_in[k] = r_shamt[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            // NOTE: every always_comb output gets a default before any conditional
            // update, so no path leaves it unassigned and no latch is inferred.
            w_shifted[k] = w_data_in[k];
            for (int j = 0; j < SHAMT_W; j++) begin
                if ((j / LEVELS_PER_STAGE) == k && w_shamt_in[k][j]) begin
                    w_shifted[k] = shift_level(w_shifted[k], w_op_in[k], 1 << j);
                end
            end
        end
    end

    // A stage advances when it is empty or everything downstream can move.
    always_comb begin
        w_adv[STAGES-1] = !r_valid[STAGES-1] || out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            w_adv[k] = !r_valid[k] || w_adv[k+1];
        end
    end

    assign in_ready  = w_adv[0] && !flush;
    assign out_valid = r_valid[STAGES-1];
    assign out_data  = r_data[STAGES-1];
    assign out_tag   = r_tag[STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the payload registers are cleared too so out_data/out_tag read 0
            // out of reset; only the valid bits matter for correctness.
            r_valid <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_data[k]  <= '0;
                r_op[k]    <= OP_SLL;
                r_tag[k]   <= '0;
                r_shamt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                // NOTE: non-blocking updates let every stage sample its upstream
                // neighbour's pre-edge value, which is what makes this a pipeline.
                if (flush) begin
                    r_valid[k] <= 1'b0;
                end else if (w_adv[k]) begin
                    r_valid[k] <= w_valid_in[k];
                    r_data[k]  <= w_shifted[k];
                    r_op[k]    <= w_op_in[k];
                    r_tag[k]   <= w_tag_in[k];
                    r_shamt[k] <= w_shamt_in[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_execution_barrel_shifter.sv
// Self-checking bench: directed scenarios on a STAGES=2 instance plus a randomized
// sweep of STAGES=1/2/5 instances against a per-bit behavioural shift model.
module tb_execution_barrel_shifter;

    localparam int LAT [3] = '{2, 1, 5};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic [4:0]  in_shamt = '0;
    logic [1:0]  in_op = '0;
    logic [4:0]  in_tag = '0;

    logic [2:0]  ir;
    logic [2:0]  ov;
    logic [31:0] od [3];
    logic [4:0]  ot [3];

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        int          cyc;
    } exp_t;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    execution_barrel_shifter #(.WIDTH(32), .SHAMT_W(5), .STAGES(2), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
        .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_tag(ot[0]));

    execution_barrel_shifter #(.WIDTH(32), .SHAMT_W(5), .STAGES(1), .TAG_W(5)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
        .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_tag(ot[1]));

    execution_barrel_shifter #(.WIDTH(32), .SHAMT_W(5), .STAGES(5), .TAG_W(5)) dut_s5 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
        .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
        .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .out_tag(ot[2]));

    // Reference: each result bit is picked from its source bit by the op's rule.
    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d,
                                              input int s);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            case (op)
                2'b00:   r[i] = (i >= s) ? d[i-s] : 1'b0;
                2'b01:   r[i] = (i + s < 32) ? d[i+s] : 1'b0;
                2'b10:   r[i] = (i + s < 32) ? d[i+s] : d[31];
                default: r[i] = d[(i + s) % 32];
            endcase
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] d,
                         input logic [4:0] s, input logic [4:0] t);
        in_valid = v;
        in_op    = op;
        in_data  = d;
        in_shamt = s;
        in_tag   = t;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
        #12;
        n_checks++;
        if (ov !== 3'b000) $display("FAIL reset_out_valid: got %b expected 000", ov);
        else n_pass++;
        n_checks++;
        if (od[0] !== 32'h0) $display("FAIL reset_out_data: got %h expected 0", od[0]);
        else n_pass++;
        n_checks++;
        if (ot[0] !== 5'd0) $display("FAIL reset_out_tag: got %0d expected 0", ot[0]);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        settle();
        n_checks++;
        if (ir[0] !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", ir[0]);
        else n_pass++;
    endtask

    task automatic test_sll_latency();
        out_ready = 1'b1;
        drive(1'b1, 2'b00, 32'h0000_0001, 5'd31, 5'd7);
        settle();
        n_checks++;
        if (ir[0] !== 1'b1) $display("FAIL sll_in_ready: got %b expected 1", ir[0]);
        else n_pass++;
        tick();
        drive(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
        settle();
        n_checks++;
        if (ov[0] !== 1'b0) $display("FAIL sll_early_valid: got %b expected 0", ov[0]);
        else n_pass++;
        tick();
        settle();
        n_checks++;
        if (ov[0] !== 1'b1 || od[0] !== 32'h8000_0000 || ot[0] !== 5'd7)
            $display("FAIL sll_result: got v=%b d=%h t=%0d expected v=1 d=80000000 t=7",
                     ov[0], od[0], ot[0]);
        else n_pass++;
        tick();
        settle();
        n_checks++;
        if (ov[0] !== 1'b0) $display("FAIL sll_pulse: got %b expected 0", ov[0]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [1:0]  ops [4] = '{2'b10, 2'b01, 2'b11, 2'b00};
        logic [31:0] dat [4] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_00F1, 32'hDEAD_BEEF};
        logic [4:0]  sh  [4] = '{5'd4, 5'd4, 5'd4, 5'd0};
        logic [31:0] exp [4] = '{32'hF800_0000, 32'h0800_0000, 32'h1000_000F, 32'hDEAD_BEEF};
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c < 4) drive(1'b1, ops[c], dat[c], sh[c], 5'(c + 1));
            else drive(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
            settle();
            if (c >= 2) begin
                n_checks++;
                if (ov[0] !== 1'b1 || od[0] !== exp[c-2] || ot[0] !== 5'(c - 1))
                    $display("FAIL b2b_%0d: got v=%b d=%h t=%0d expected v=1 d=%h t=%0d",
                             c - 2, ov[0], od[0], ot[0], exp[c-2], c - 1);
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_stall();
        logic [1:0]  op [3];
        logic [31:0] d [3];
        logic [4:0]  s [3];
        logic [31:0] exp [3];
        int acc = 0;
        int got = 0;
        for (int i = 0; i < 3; i++) begin
            op[i]  = 2'($urandom);
            d[i]   = $urandom;
            s[i]   = 5'($urandom_range(1, 31));
            exp[i] = ref_shift(op[i], d[i], int'(s[i]));
        end
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, op[acc], d[acc], s[acc], 5'(20 + acc));
            settle();
            if (c >= 2 && ov[0]) begin
                n_checks++;
                if (od[0] !== exp[0] || ot[0] !== 5'd20)
                    $display("FAIL stall_hold_%0d: got d=%h t=%0d expected d=%h t=20",
                             c, od[0], ot[0], exp[0]);
                else n_pass++;
            end
            if (ir[0]) acc++;
            tick();
        end
        settle();
        n_checks++;
        if (acc !== 2 || ir[0] !== 1'b0 || ov[0] !== 1'b1)
            $display("FAIL stall_accept: got acc=%0d ready=%b valid=%b expected acc=2 ready=0 valid=1",
                     acc, ir[0], ov[0]);
        else n_pass++;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (acc < 3) drive(1'b1, op[acc], d[acc], s[acc], 5'(20 + acc));
            else drive(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
            settle();
            if (ov[0]) begin
                n_checks++;
                if (got >= 3)
                    $display("FAIL stall_dup: got extra d=%h expected no output", od[0]);
                else if (od[0] !== exp[got] || ot[0] !== 5'(20 + got))
                    $display("FAIL stall_drain_%0d: got d=%h t=%0d expected d=%h t=%0d",
                             got, od[0], ot[0], exp[got], 20 + got);
                else n_pass++;
                got++;
            end
            if (in_valid && ir[0]) acc++;
            tick();
        end
        n_checks++;
        if (got !== 3 || acc !== 3)
            $display("FAIL stall_count: got out=%0d acc=%0d expected out=3 acc=3", got, acc);
        else n_pass++;
    endtask

    task automatic test_flush();
        logic [31:0] dd = $urandom;
        logic [31:0] exp_d = ref_shift(2'b11, dd, 13);
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 32'h1234_5678, 5'd3, 5'd1);
        settle();
        tick();
        drive(1'b1, 2'b01, 32'h8765_4321, 5'd5, 5'd2);
        settle();
        tick();
        drive(1'b1, 2'b10, 32'hCAFE_F00D, 5'd7, 5'd3);
        flush = 1'b1;
        settle();
        n_checks++;
        if (ir[0] !== 1'b0) $display("FAIL flush_in_ready: got %b expected 0", ir[0]);
        else n_pass++;
        tick();
        flush = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            settle();
            n_checks++;
            if (ov[0] !== 1'b0) $display("FAIL flush_leak_%0d: got valid=%b d=%h expected valid=0",
                                         c, ov[0], od[0]);
            else n_pass++;
            tick();
        end
        drive(1'b1, 2'b11, dd, 5'd13, 5'd9);
        settle();
        tick();
        drive(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
        settle();
        tick();
        settle();
        n_checks++;
        if (ov[0] !== 1'b1 || od[0] !== exp_d || ot[0] !== 5'd9)
            $display("FAIL flush_recover: got v=%b d=%h t=%0d expected v=1 d=%h t=9",
                     ov[0], od[0], ot[0], exp_d);
        else n_pass++;
        tick();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        drive(1'b1, 2'b00, 32'hFFFF_FFFF, 5'd1, 5'd4);
        settle();
        tick();
        drive(1'b1, 2'b01, 32'hFFFF_FFFF, 5'd2, 5'd5);
        settle();
        tick();
        drive(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
        settle();
        n_checks++;
        if (ov[0] !== 1'b1) $display("FAIL areset_inflight: got %b expected 1", ov[0]);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ov[0] !== 1'b0 || od[0] !== 32'h0 || ot[0] !== 5'd0)
            $display("FAIL areset_immediate: got v=%b d=%h t=%0d expected v=0 d=0 t=0",
                     ov[0], od[0], ot[0]);
        else n_pass++;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            settle();
            n_checks++;
            if (ov[0] !== 1'b0) $display("FAIL areset_after_%0d: got %b expected 0", c, ov[0]);
            else n_pass++;
        end
    endtask

    task automatic test_random_backpressure();
        exp_t q[$];
        exp_t e;
        logic prev_stall = 1'b0;
        logic [31:0] prev_d = '0;
        logic exp_ready;
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom % 4) != 0, 2'($urandom), $urandom, 5'($urandom), 5'($urandom));
            out_ready = ($urandom % 3) != 0;
            flush = ($urandom % 50) == 0;
            settle();
            exp_ready = (q.size() < 2 || out_ready) && !flush;
            n_checks++;
            if (ir[0] !== exp_ready)
                $display("FAIL rbp_ready_%0d: got %b expected %b", c, ir[0], exp_ready);
            else n_pass++;
            if (prev_stall) begin
                n_checks++;
                if (ov[0] !== 1'b1 || od[0] !== prev_d)
                    $display("FAIL rbp_hold_%0d: got v=%b d=%h expected v=1 d=%h",
                             c, ov[0], od[0], prev_d);
                else n_pass++;
            end
            if (flush) begin
                q.delete();
            end else begin
                if (ov[0] && out_ready) begin
                    n_checks++;
                    if (q.size() == 0) begin
                        $display("FAIL rbp_spurious_%0d: got d=%h expected no output", c, od[0]);
                    end else begin
                        e = q.pop_front();
                        if (od[0] !== e.data || ot[0] !== e.tag)
                            $display("FAIL rbp_data_%0d: got d=%h t=%0d expected d=%h t=%0d",
                                     c, od[0], ot[0], e.data, e.tag);
                        else n_pass++;
                    end
                end
                if (in_valid && ir[0])
                    q.push_back('{ref_shift(in_op, in_data, int'(in_shamt)), in_tag, cyc});
            end
            prev_stall = ov[0] && !out_ready && !flush;
            prev_d = od[0];
            tick();
        end
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
        for (int c = 0; c < 6; c++) begin
            settle();
            if (ov[0]) begin
                n_checks++;
                if (q.size() == 0) begin
                    $display("FAIL rbp_drain_spurious: got d=%h expected no output", od[0]);
                end else begin
                    e = q.pop_front();
                    if (od[0] !== e.data || ot[0] !== e.tag)
                        $display("FAIL rbp_drain: got d=%h t=%0d expected d=%h t=%0d",
                                 od[0], ot[0], e.data, e.tag);
                    else n_pass++;
                end
            end
            tick();
        end
        n_checks++;
        if (q.size() != 0) $display("FAIL rbp_lost: got %0d pending expected 0", q.size());
        else n_pass++;
    endtask

    task automatic test_sweep();
        exp_t hist[$];
        int rp [3] = '{0, 0, 0};
        rst_n = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
        #3;
        rst_n = 1'b1;
        tick();
        for (int c = 0; c < 10006; c++) begin
            if (c < 10000)
                drive(($urandom % 4) != 0, 2'($urandom), $urandom, 5'($urandom), 5'($urandom));
            else
                drive(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
            settle();
            if (in_valid) begin
                n_checks++;
                if (ir !== 3'b111) $display("FAIL sweep_ready_%0d: got %b expected 111", c, ir);
                else n_pass++;
            end
            for (int d = 0; d < 3; d++) begin
                if (ov[d]) begin
                    n_checks++;
                    if (rp[d] >= hist.size())
                        $display("FAIL sweep_spurious_s%0d: got d=%h expected no output",
                                 LAT[d], od[d]);
                    else if (od[d] !== hist[rp[d]].data || ot[d] !== hist[rp[d]].tag ||
                             cyc - hist[rp[d]].cyc != LAT[d])
                        $display("FAIL sweep_s%0d_%0d: got d=%h t=%0d lat=%0d expected d=%h t=%0d lat=%0d",
                                 LAT[d], rp[d], od[d], ot[d], cyc - hist[rp[d]].cyc,
                                 hist[rp[d]].data, hist[rp[d]].tag, LAT[d]);
                    else n_pass++;
                    rp[d]++;
                end
            end
            if (in_valid)
                hist.push_back('{ref_shift(in_op, in_data, int'(in_shamt)), in_tag, cyc});
            tick();
        end
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (rp[d] != hist.size())
                $display("FAIL sweep_count_s%0d: got %0d expected %0d", LAT[d], rp[d], hist.size());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_sll_latency();
        test_back_to_back();
        test_stall();
        test_flush();
        test_async_reset();
        test_random_backpressure();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/execution_barrel_shifter.md
Name: execution_barrel_shifter

Overview:
- Parametrised, pipelined shifter for the EX stage; successor to the fixed shift-left-by-2 used for branch offsets.
- Performs SLL, SRL, SRA and ROTR by a runtime shift amount over STAGES register stages.
- Carries a destination tag alongside the data.
- Uses a valid/ready handshake with stall back-pressure and a flush, so it can sit in the EX stage under hazard control.

Parameters:
- WIDTH, 32: data width; must be a power of two, 8..64.
- SHAMT_W, 5: shift-amount width; must equal log2(WIDTH).
- STAGES, 2: pipeline register stages; range 1..SHAMT_W.
- TAG_W, 5: width of the passthrough tag (destination register number).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all in-flight operations.
- in_valid  in  1  input operation valid.
- in_ready  out  1  block can accept an input this cycle.
- in_data  in  WIDTH  operand.
- in_shamt  in  SHAMT_W  shift amount.
- in_op  in  2  operation select: 00 SLL, 01 SRL, 10 SRA, 11 ROTR.
- in_tag  in  TAG_W  passthrough tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  shifted result.
- out_tag  out  TAG_W  tag matching out_data.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all stage valid bits, data, tag, op and remaining-shamt registers clear to 0;
  - out_valid=0, out_data=0, out_tag=0;
  - in_ready=1 once rst_n is released.
- Structure: the shifter is a log2 cascade of SHAMT_W levels; level j shifts by 2^j when shamt bit j is set.
- Level partition: with L=ceil(SHAMT_W/STAGES), stage k applies levels k*L .. min((k+1)*L, SHAMT_W)-1 combinationally, then registers the result.
- Register contents per stage: valid, data, op, tag, shamt.
- Latency: an accepted input appears on out_* exactly STAGES cycles later when there is no stall. Throughput is 1 operation per cycle.
- Handshake:
  - a transfer occurs when valid and ready are both high at a clock edge;
  - stage k may advance when it is empty or stage k+1 may advance;
  - the last stage may advance when it is empty or out_ready=1;
  - in_ready is that advance condition for stage 0, and is combinational from out_ready through the stage valids;
  - out_* hold stable while out_valid=1 and out_ready=0.
- Operation semantics:
  - SLL fills with zeros;
  - SRL fills with zeros;
  - SRA fills with in_data[WIDTH-1], sampled at input and carried through the stages;
  - ROTR rotates right.
  - shamt=0 passes data unchanged for every op.
  - shamt=WIDTH-1 is the maximum; there are no out-of-range amounts by construction.
- Flush:
  - flush=1 clears every stage valid bit at the edge;
  - an input presented in the same cycle is dropped, and in_ready is forced to 0 while flush=1;
  - data registers need not clear;
  - out_valid=0 on the following cycle.
- Simultaneous events:
  - in a full pipe with out_ready=1 and in_valid=1, one result leaves and one input enters in the same cycle;
  - flush overrides every transfer;
  - rst_n overrides flush.
- Reset mid-operation: all in-flight operations are lost and no partial result is emitted.
- Op 11 and tag are carried unmodified; out_tag always matches the data it was issued with.

Test Plan:
- WIDTH=32, STAGES=2: issue SLL 0x0000_0001 shamt=31, tag=7 -> 2 cycles later out_data=0x8000_0000, out_tag=7, out_valid pulses for 1 cycle.
- Back-to-back SRA 0x8000_0000 shamt=4, SRL 0x8000_0000 shamt=4, ROTR 0x0000_00F1 shamt=4, shamt=0 pass of 0xDEAD_BEEF -> out_data=0xF800_0000, 0x0800_0000, 0x1000_000F, 0xDEAD_BEEF on consecutive cycles.
- Hold out_ready=0 with 3 inputs offered -> pipe accepts exactly STAGES operations, in_ready=0 after that, out_data stable; raise out_ready -> results drain in order with no loss or duplication.
- Full pipe, then flush=1 with in_valid=1 for 1 cycle -> out_valid=0 next cycle, flushed and concurrent inputs never appear, next input returns after STAGES cycles.
- Assert rst_n=0 asynchronously between clock edges with 2 operations in flight -> out_valid and out_data go to 0 immediately, no output after release.
- Sweep STAGES=1 and STAGES=5 with random op/data/shamt (10k vectors) against a behavioural model -> zero mismatches, latency equals STAGES.
